// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM states, default
// counter width and the counter saturation value.
package pwm_capture_pkg;

  typedef enum logic [1:0] {StIdle, StSync, StHigh, StLow} state_e;

  localparam int unsigned DefaultW = 9;

  function automatic int unsigned sat_max(int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_edge_detect.sv
// Input stage for pwm_capture: optional 2-flop synchronizer (PWM_CAPTURE_SYNC_EN),
// the s / s_d sample registers and the rise/fall strobes derived from them.
module pwm_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic s_in;
  logic s_q;
  logic s_d_q;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

  assign s_in = sync_q[1];
`else
  // Only safe when pwm_in is already launched from clk-domain logic.
  assign s_in = pwm_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= 1'b0;
      s_d_q <= 1'b0;
    end else begin
      s_q   <= s_in;
      s_d_q <= s_q;
    end
  end

  assign s    = s_q;
  assign rise = s_q & ~s_d_q;
  assign fall = ~s_q & s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of pwm_in in clk cycles, with a
// timeout that flags a waveform stuck at 0% or 100% duty.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         pwm_in,
  output logic [W-1:0] high_time,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         stuck,
  output logic         stuck_lvl
);

  localparam logic [W-1:0] SatMax = W'(sat_max(W));
  localparam logic [W-1:0] One    = W'(1);

  logic s;
  logic rise;
  logic fall;

  pwm_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  state_e       state_q, state_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] per_q, per_d;
  logic [W-1:0] high_time_q, high_time_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         stuck_q, stuck_d;
  logic         stuck_lvl_q, stuck_lvl_d;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    per_d       = per_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    if (!en) begin
      state_d = StIdle;
      hi_d    = '0;
      per_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          hi_d    = '0;
          per_d   = '0;
          state_d = StSync;
        end
        StSync: begin
          if (rise) begin
            state_d = StHigh;
            hi_d    = One;
            per_d   = One;
          end
        end
        StHigh: begin
          if (per_q == SatMax) begin
            stuck_d     = 1'b1;
            stuck_lvl_d = s;
            state_d     = StSync;
          end else begin
            per_d = per_q + One;
            if (fall) begin
              state_d = StLow;
            end else if (hi_q != SatMax) begin
              hi_d = hi_q + One;
            end
          end
        end
        StLow: begin
          // A closing rise takes priority over a timeout in the same cycle.
          if (rise) begin
            high_time_d = hi_q;
            period_d    = per_q;
            valid_d     = 1'b1;
            stuck_d     = 1'b0;
            state_d     = StHigh;
            hi_d        = One;
            per_d       = One;
          end else if (per_q == SatMax) begin
            stuck_d     = 1'b1;
            stuck_lvl_d = s;
            state_d     = StSync;
          end else begin
            per_d = per_q + One;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hi_q        <= '0;
      per_q       <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      per_q       <= per_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign high_time = high_time_q;
  assign period    = period_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign stuck_lvl = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveforms are built as cycle arrays and
// expected reports are derived from rise/fall times with plain arithmetic.
module tb_pwm_capture;

  localparam int unsigned W = 9;
  localparam int Max  = (1 << W) - 1;
  localparam int MaxN = 6000;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         pwm_in;
  logic [W-1:0] high_time;
  logic [W-1:0] period;
  logic         valid;
  logic         stuck;
  logic         stuck_lvl;

  int n_checks = 0;
  int n_fail   = 0;

  bit wave [MaxN];
  bit en_w [MaxN];
  int n;
  int gen_cnt;

  bit ev_valid [MaxN+8];
  int ev_ht    [MaxN+8];
  int ev_per   [MaxN+8];
  bit ev_stuck [MaxN+8];
  bit ev_lvl   [MaxN+8];

  int valid_times[$];
  int stuck_times[$];

  always #5 clk = ~clk;

  pwm_capture #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .valid     (valid),
    .stuck     (stuck),
    .stuck_lvl (stuck_lvl)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_wave();
    n       = 0;
    gen_cnt = 0;
  endtask

  task automatic add_seg(input bit lvl, input int len);
    for (int i = 0; i < len; i++) begin
      if (n < MaxN) begin
        wave[n] = lvl;
        en_w[n] = 1'b1;
        n++;
      end
    end
  endtask

  // Counter-plus-compare generator: high while the phase counter is below cmp.
  task automatic gen(input int per, input int cmp, input int len);
    for (int i = 0; i < len; i++) begin
      add_seg(gen_cnt < cmp, 1);
      gen_cnt = (gen_cnt + 1) % per;
    end
  endtask

  // Reference: a report closes each rise-to-rise interval of at most Max cycles
  // that began at a rise seen while enabled; Max cycles without a closing rise
  // flags stuck with the level present at that moment.
  task automatic build_expect();
    bit armed = 1'b0;
    int lr = 0;
    int lf = 0;
    bit prev;
    for (int c = 0; c < MaxN + 8; c++) begin
      ev_valid[c] = 1'b0;
      ev_stuck[c] = 1'b0;
      ev_ht[c]    = 0;
      ev_per[c]   = 0;
      ev_lvl[c]   = 1'b0;
    end
    for (int c = 0; c < n; c++) begin
      prev = (c == 0) ? 1'b0 : wave[c-1];
      if (!en_w[c]) begin
        armed = 1'b0;
      end else if (wave[c] && !prev) begin
        if (armed) begin
          ev_valid[c+Lat] = 1'b1;
          ev_ht[c+Lat]    = lf - lr;
          ev_per[c+Lat]   = c - lr;
        end
        armed = 1'b1;
        lr    = c;
      end else if (armed && (c - lr == Max)) begin
        ev_stuck[c+Lat] = 1'b1;
        ev_lvl[c+Lat]   = wave[c];
        armed           = 1'b0;
      end
      if (!wave[c] && prev) lf = c;
    end
  endtask

  task automatic run_scenario(input string name);
    int  e_ht = 0, e_per = 0;
    bit  e_valid, e_stuck = 1'b0, e_lvl = 1'b0;
    bit  stuck_prev = 1'b0;
    // Reset lands while the previous waveform is still applied.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq({name, " reset high_time"}, int'(high_time), 0);
    check_eq({name, " reset period"},    int'(period),    0);
    check_eq({name, " reset valid"},     int'(valid),     0);
    check_eq({name, " reset stuck"},     int'(stuck),     0);
    check_eq({name, " reset stuck_lvl"}, int'(stuck_lvl), 0);
    pwm_in = 1'b0;
    en     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    build_expect();
    valid_times.delete();
    stuck_times.delete();
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      e_valid = ev_valid[c];
      if (ev_valid[c]) begin
        e_ht    = ev_ht[c];
        e_per   = ev_per[c];
        e_stuck = 1'b0;
      end
      if (ev_stuck[c]) begin
        e_stuck = 1'b1;
        e_lvl   = ev_lvl[c];
      end
      check_eq($sformatf("%s c%0d valid", name, c),     int'(valid),     int'(e_valid));
      check_eq($sformatf("%s c%0d high_time", name, c), int'(high_time), e_ht);
      check_eq($sformatf("%s c%0d period", name, c),    int'(period),    e_per);
      check_eq($sformatf("%s c%0d stuck", name, c),     int'(stuck),     int'(e_stuck));
      check_eq($sformatf("%s c%0d stuck_lvl", name, c), int'(stuck_lvl), int'(e_lvl));
      if (valid) valid_times.push_back(c);
      if (stuck && !stuck_prev) stuck_times.push_back(c);
      stuck_prev = stuck;
      pwm_in = wave[c];
      en     = en_w[c];
    end
  endtask

  initial begin
    int h, l, win;
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;

    // 256/64 generator, left mid-high so the next reset hits a live measurement.
    clear_wave();
    add_seg(1'b0, 4);
    gen(256, 64, 256 * 5 + 20);
    run_scenario("p256c64");
    check_eq("p256c64 valid count", valid_times.size(), 5);
    if (valid_times.size() > 0) check_eq("p256c64 first valid", valid_times[0], 260 + Lat);
    for (int i = 1; i < valid_times.size(); i++)
      check_eq("p256c64 valid spacing", valid_times[i] - valid_times[i-1], 256);
    check_eq("p256c64 final high_time", int'(high_time), 64);
    check_eq("p256c64 final period", int'(period), 256);

    // Duty step 64 -> 200 while the phase counter is still below 64.
    clear_wave();
    add_seg(1'b0, 4);
    gen(256, 64, 256 * 2 + 30);
    gen(256, 200, 256 * 3);
    run_scenario("duty_step");
    check_eq("duty_step final high_time", int'(high_time), 200);
    check_eq("duty_step final period", int'(period), 256);

    // Stuck high, stuck low, then a 511-cycle period and a 512-cycle period.
    clear_wave();
    add_seg(1'b0, 4);
    add_seg(1'b1, 100);
    add_seg(1'b0, 156);
    add_seg(1'b1, 700);
    add_seg(1'b0, 700);
    add_seg(1'b1, 50);
    add_seg(1'b0, 600);
    add_seg(1'b1, 100);
    add_seg(1'b0, 411);
    add_seg(1'b1, 100);
    add_seg(1'b0, 412);
    add_seg(1'b1, 10);
    add_seg(1'b0, 10);
    add_seg(1'b1, 5);
    add_seg(1'b0, 10);
    run_scenario("stuck");
    if (stuck_times.size() > 0) check_eq("stuck first set", stuck_times[0], 260 + Max + Lat);
    else check_eq("stuck first set", -1, 260 + Max + Lat);

    // Minimum waveform: 1 high, 1 low.
    clear_wave();
    add_seg(1'b0, 4);
    for (int i = 0; i < 40; i++) begin
      add_seg(1'b1, 1);
      add_seg(1'b0, 1);
    end
    add_seg(1'b0, 6);
    run_scenario("min");
    check_eq("min final high_time", int'(high_time), 1);
    check_eq("min final period", int'(period), 2);

    // Random high/low lengths, occasionally long enough to time out.
    clear_wave();
    add_seg(1'b0, 4);
    while (n < 3500) begin
      h = (($urandom % 8) == 0) ? int'($urandom_range(440, 600)) : int'($urandom_range(1, 250));
      l = (($urandom % 8) == 0) ? int'($urandom_range(440, 600)) : int'($urandom_range(1, 250));
      add_seg(1'b1, h);
      add_seg(1'b0, l);
    end
    run_scenario("random");

    // Enable dropped for 10 cycles mid-low.
    clear_wave();
    add_seg(1'b0, 4);
    gen(256, 64, 612);
    win = n;
    gen(256, 64, 768);
    for (int i = win; i < win + 10; i++) en_w[i] = 1'b0;
    run_scenario("en_drop");
    begin
      int cnt = 0;
      foreach (valid_times[i])
        if (valid_times[i] >= win && valid_times[i] < 1028 + Lat) cnt++;
      check_eq("en_drop valids in gap", cnt, 0);
    end
    check_eq("en_drop final high_time", int'(high_time), 64);
    check_eq("en_drop final period", int'(period), 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receiving end of the LED PWM chain: the counter-plus-compare generator drives the waveform, and this block recovers the duty and period from it for self-check and readback. It sits beside the PWM generator and samples either the on-chip PWM net or an external pin.

## Interface
- `W`, default 9: width of the high-time and period counters; the maximum measurable value is 2^W-1.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `en` input, 1 bit: capture enable, level-sensitive, synchronous.
- `pwm_in` input, 1 bit: PWM waveform under measurement.
- `high_time` output, W bits: high cycles of the last complete period.
- `period` output, W bits: total cycles of the last complete period, measured rise to rise.
- `valid` output, 1 bit: one-cycle pulse when `high_time` and `period` update.
- `stuck` output, 1 bit: set when no complete period is seen within 2^W-1 cycles; cleared on the next `valid`.
- `stuck_lvl` output, 1 bit: input level when `stuck` was set (1 means 100% duty, 0 means 0% duty).

## Operation
- Sample path: `s` is `pwm_in` after the input stage (see Configuration). `s_d` is `s` delayed by one register.
  - Rise means `s=1` and `s_d=0`. Fall means `s=0` and `s_d=1`.
- FSM states are IDLE, SYNC, HIGH and LOW.
  - IDLE: entered when `en=0`, from any state, at the next clock. Counters clear. All outputs hold their values. Goes to SYNC when `en=1`.
  - SYNC: waits for the first rise, so partial periods are never reported. On rise, go to HIGH and set `hi_cnt=1`, `per_cnt=1`.
  - HIGH: both counters increment each cycle. On fall, go to LOW; `hi_cnt` freezes.
  - LOW: `per_cnt` increments each cycle. On rise:
    - `high_time<=hi_cnt` and `period<=per_cnt`;
    - `valid=1` for one cycle;
    - `stuck<=0`;
    - go to HIGH with `hi_cnt=1`, `per_cnt=1`.
- Both counters saturate at 2^W-1 and never wrap.
- Timeout: in HIGH or LOW, when `per_cnt` reaches 2^W-1 without a closing rise:
  - `stuck<=1` and `stuck_lvl<=s`;
  - go to SYNC;
  - `high_time` and `period` are not updated.
- A rise and the timeout in the same cycle: the rise wins, `valid` fires and `stuck` is not set.
- A glitch narrower than one sample period is either missed or counted as a 1-cycle pulse. No filtering is performed.
- Reset values: `high_time=0`, `period=0`, `valid=0`, `stuck=0`, `stuck_lvl=0`; FSM in IDLE; sample registers 0.
- Asserting `rst` mid-measurement aborts the measurement. No `valid` is produced.

## Timing
- `valid` is asserted in the cycle after the register stage that first shows the closing rise on `s`.
- Input-to-`valid` latency from the `pwm_in` rising edge:
  - 2 cycles without the synchronizer;
  - 4 cycles with it.
- `high_time` and `period` change only together with `valid`. They are stable between pulses.
- The minimum reportable period is 2 (high_time 1, low 1). `valid` can pulse at most once every 2 cycles.
- Deassertion of `en` takes effect at the next clock. A measurement in flight is discarded.

## Configuration
- Macro: `PWM_CAPTURE_SYNC_EN`.
- Defined: `pwm_in` passes through a 2-flop synchronizer before `s`. Required for external or asynchronous pins. Adds 2 cycles of latency.
- Undefined: `s` is `pwm_in` registered once. For use only when `pwm_in` comes from `clk`-domain logic.
- Measured values are identical in both builds for a synchronous input; only the latency differs.

## Structure
- Shared package holds:
  - the FSM state enum: IDLE, SYNC, HIGH, LOW;
  - the default `W`;
  - the saturation constant 2^W-1 as a function of `W`.
- One sub-module, `pwm_edge_detect`:
  - contains the optional synchronizer, the `s`/`s_d` registers and the rise/fall outputs;
  - contains the only `ifdef`.
- The FSM, counters and output registers stay in `pwm_capture`.

## Test plan
- Generator at period 256, compare 64 (high 64, low 192), `en=1`:
  - first `valid` follows the second rise;
  - `high_time=64`, `period=256`;
  - `valid` repeats every 256 cycles.
- Duty steps from 64 to 200 mid-period: the next report is either 64/256 or 200/256, never mixed. The report after that is exactly 200/256.
- `pwm_in` held at 1 after one rise (W=9):
  - `stuck=1` and `stuck_lvl=1` exactly 511 cycles after the rise;
  - no `valid`;
  - `high_time` and `period` keep their old values.
- Minimum waveform 1 high / 1 low: `high_time=1`, `period=2` on every valid. `valid` never coincides with a stale value.
- `rst` pulsed mid-HIGH: all outputs are 0 immediately. Measurement restarts at SYNC; the first `valid` follows two rises after `rst` is released.
- `en` dropped mid-LOW for 10 cycles and then raised: no `valid` during or right after. Outputs hold their prior values until a full new period completes.
